// File: rtl/piradip_word_to_symbol.sv
// Word-to-symbol serializer: loads WIDTH-bit words from an AXI-stream input and
// shifts them out as WIDTH/SYM_WIDTH symbols, carrying word tlast onto the final symbol.
module piradip_word_to_symbol #(
  parameter int WIDTH     = 32,
  parameter int SYM_WIDTH = 1,
  parameter int MSB_FIRST = 1,
  localparam int NSYM     = WIDTH / SYM_WIDTH,
  localparam int LW       = $clog2(NSYM + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 align,
  input  logic [WIDTH-1:0]     words_tdata,
  input  logic                 words_tlast,
  input  logic                 words_tvalid,
  output logic                 words_tready,
  output logic [SYM_WIDTH-1:0] sym_tdata,
  output logic                 sym_tlast,
  output logic                 sym_tvalid,
  input  logic                 sym_tready,
  output logic [LW-1:0]        level,
  output logic                 empty
);

  if (WIDTH % SYM_WIDTH != 0) begin : g_bad_width
    $error("piradip_word_to_symbol: WIDTH must be a multiple of SYM_WIDTH");
  end

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [LW-1:0]    cnt;
  logic             last;
  logic             cnt_one;
  logic             sym_xfer;
  logic             word_xfer;

  assign cnt_one      = (cnt == LW'(1));
  assign sym_tvalid   = (cnt != '0) & ~align;
  assign sym_tlast    = last & cnt_one;
  assign words_tready = ~align & ((cnt == '0) | (cnt_one & sym_tready));
  assign level        = cnt;
  assign empty        = (cnt == '0);
  assign sym_xfer     = sym_tvalid & sym_tready;
  assign word_xfer    = words_tvalid & words_tready;

  // Zero fill keeps sym_tdata at 0 once a word has fully drained.
  if (MSB_FIRST != 0) begin : g_msb
    assign sym_tdata = sr[WIDTH-1 -: SYM_WIDTH];
    assign sr_next   = sr << SYM_WIDTH;
  end else begin : g_lsb
    assign sym_tdata = sr[SYM_WIDTH-1:0];
    assign sr_next   = sr >> SYM_WIDTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sr   <= '0;
      last <= 1'b0;
    end else if (align) begin
      cnt  <= '0;
      last <= 1'b0;
    end else begin
      if (sym_xfer) begin
        cnt <= cnt - LW'(1);
        sr  <= sr_next;
      end
      // A reload on the final symbol's beat wins, giving gap-free back-to-back words.
      if (word_xfer) begin
        sr   <= words_tdata;
        cnt  <= LW'(NSYM);
        last <= words_tlast;
      end
    end
  end

endmodule
